ks_sequencer: RTL and testbench
===============================

KS_SEQUENCER -- requirements
Module: ks_sequencer

Interface
REQ-001 Parameter MEM_LATENCY, default 2: mem_req cycles per access in fixed mode; legal range 1..15.
REQ-002 Parameter MEM_MODE, default MEM_FIXED: MEM_FIXED counts MEM_LATENCY; MEM_HANDSHAKE waits for mem_ready.
REQ-003 Parameter OV_SIGNED, default 0: BOV/BNOV test unsigned_overflow (0) or signed_overflow (1).
REQ-004 Parameter OP_W, default 2: operation width; legal range 2..4; values above 2'b11 unused.
REQ-005 Clock and reset: one clock, clk; reset rst, synchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 decoded_instruction  in  decoded_instruction_type  instruction from decoder.
REQ-009 zero_op, neg_op, unsigned_overflow, signed_overflow  in  1 each  registered ALU flags.
REQ-010 mem_ready  in  1  memory access complete, read in MEM_HANDSHAKE only.
REQ-011 step_mode  in  1  single-step enable; step  in  1  advance pulse.
REQ-012 branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, ram_write_enable  out  1 each  datapath controls.
REQ-013 operation  out  OP_W  ALU op: ADD=0, SUB=1, AND=2, OR=3.
REQ-014 mem_req  out  1  memory access active; halt  out  1  halted; retired  out  1  one-cycle instruction-complete pulse.

Function
REQ-015 States: FETCH, LATCH_IR, DECODE, EXEC, MEM_ADDR, LOAD_WB, STORE_WR, BR_EVAL, STEP_HOLD, HALTED.
REQ-016 Outputs are combinational from state plus inputs; every output not asserted by the current state is 0, and operation defaults to ADD.
REQ-017 Memory wait, fixed mode: mem_req held exactly MEM_LATENCY cycles, then the next state is taken.
REQ-018 Memory wait, handshake mode: mem_req held until the cycle where mem_ready=1 inclusive; mem_ready outside mem_req is ignored.
REQ-019 FETCH: mem_req=1, addr_sel=0; -> LATCH_IR when the wait completes.
REQ-020 LATCH_IR: ir_enable=1, pc_enable=1; -> DECODE.
REQ-021 DECODE dispatch:
  - ADD/SUB/AND/OR/MOVE -> EXEC
  - LOAD -> MEM_ADDR; STORE -> STORE_WR
  - BRANCH and conditional branches -> BR_EVAL
  - HALT -> HALTED
  - any other value -> retire (no datapath strobes).
REQ-022 EXEC: write_reg_enable=1, operation per instruction (MOVE uses OR); flags_reg_enable=1 except for MOVE; retire.
REQ-023 MEM_ADDR (LOAD): addr_sel=1, c_sel=1, mem_req=1; -> LOAD_WB on wait completion.
REQ-024 LOAD_WB: addr_sel=1, c_sel=1, write_reg_enable=1; retire.
REQ-025 STORE_WR: addr_sel=1, mem_req=1, ram_write_enable=1 for the whole wait; retire on completion.
REQ-026 BR_EVAL: condition taken -> branch=1, pc_enable=1.
  - BRANCH always taken.
  - BZERO/BNZERO test zero_op; BNEG/BNNEG test neg_op.
  - BOV/BNOV test the flag selected by OV_SIGNED.
  - Retire.
REQ-027 Retire: retired=1 in the final cycle of every instruction; next state STEP_HOLD if step_mode=1, else FETCH.
REQ-028 STEP_HOLD: all strobes 0; -> FETCH on the cycle after step=1 is sampled; step outside STEP_HOLD is ignored.
REQ-029 HALTED: halt=1; stays in HALTED until rst; step and mem_ready have no effect.
REQ-030 Latency (fixed mode, latency L): ALU instruction = L+3 cycles; LOAD = 2L+3; STORE = 2L+2; branch = L+3.
REQ-031 Inputs decoded_instruction and flags are sampled in DECODE and BR_EVAL only; changes in other states have no effect.

Reset
REQ-032 rst=1 at a clock edge forces FETCH on that edge, from any state including mid-wait and HALTED.
REQ-033 While rst is asserted, all outputs are 0 and the wait counter is cleared.
REQ-034 The first mem_req appears in the cycle after rst deasserts.

Structure
REQ-035 Package k_and_s_pkg gains:
  - the sequencer state enum
  - the ALU op constants
  - the mem mode enum (MEM_FIXED, MEM_HANDSHAKE).
REQ-036 One sub-module, mem_wait_timer: a 4-bit down-counter producing wait_done per REQ-017/018, instantiated once and restarted at entry to each mem_req state.

Verification
REQ-037 Fixed mode, MEM_LATENCY=3, ADD -> mem_req for 3 cycles, then ir_enable, then write_reg_enable+flags_reg_enable with operation=0; retired in cycle 6.
REQ-038 Handshake mode, LOAD, mem_ready on the 5th fetch cycle and the 2nd data cycle -> LOAD_WB strobes c_sel+write_reg_enable; total 10 cycles.
REQ-039 BNOV with OV_SIGNED=1, signed_overflow=0 and unsigned_overflow=1 -> branch=1 and pc_enable=1 in BR_EVAL; BZERO with zero_op=0 -> no pc_enable.
REQ-040 step_mode=1, MOVE -> enters STEP_HOLD with flags_reg_enable never 1; step pulse after 7 idle cycles -> mem_req the following cycle.
REQ-041 HALT, then 20 cycles with step and mem_ready toggling -> halt stays 1; rst=1 for 1 cycle -> FETCH with mem_req=1 next cycle.
REQ-042 rst asserted mid STORE_WR wait -> ram_write_enable=0 in the reset cycle; the sequence restarts at FETCH.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S processor control path: decoded instructions,
// sequencer states, memory wait modes and ALU operation codes.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_LATCH_IR  = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_LOAD_WB   = 4'd5,
        S_STORE_WR  = 4'd6,
        S_BR_EVAL   = 4'd7,
        S_STEP_HOLD = 4'd8,
        S_HALTED    = 4'd9
    } seq_state_e;

    typedef enum logic {
        MEM_FIXED     = 1'b0,
        MEM_HANDSHAKE = 1'b1
    } mem_mode_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    function automatic logic is_mem_state(input seq_state_e s);
        return (s == S_FETCH) || (s == S_MEM_ADDR) || (s == S_STORE_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: flags the final cycle of a mem_req window, either after a
// fixed number of cycles or when the memory reports ready.
module mem_wait_timer
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter mem_mode_e   MEM_MODE    = MEM_FIXED
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_restart,
    input  logic i_mem_ready,
    output logic o_wait_done
);

    logic [3:0] r_count;
    logic [3:0] w_count_now;

    // The first cycle of a window sees the full latency, later cycles what is left.
    assign w_count_now = i_restart ? 4'(MEM_LATENCY) : r_count;

    // Completion decode for the current cycle.
    always_comb begin
        if (!i_active) begin
            o_wait_done = 1'b0;
        end else if (MEM_MODE == MEM_HANDSHAKE) begin
            o_wait_done = i_mem_ready;
        end else begin
            o_wait_done = (w_count_now == 4'd1);
        end
    end

    // Remaining-cycles down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if ((MEM_MODE == MEM_FIXED) && i_active && !o_wait_done) begin
            r_count <= w_count_now - 4'd1;
        end else begin
            r_count <= 4'd0;
        end
    end

endmodule

// File: rtl/ks_sequencer.sv
// Multi-cycle control sequencer for the K-and-S datapath: fetch, decode and
// execute each instruction, generating the datapath strobes per state.
module ks_sequencer
    import k_and_s_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter mem_mode_e   MEM_MODE    = MEM_FIXED,
    parameter bit          OV_SIGNED   = 1'b0,
    parameter int unsigned OP_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    input  logic                    mem_ready,
    input  logic                    step_mode,
    input  logic                    step,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    write_reg_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic [OP_W-1:0]         operation,
    output logic                    mem_req,
    output logic                    halt,
    output logic                    retired
);

    seq_state_e              r_state;
    seq_state_e              w_next_state;
    seq_state_e              w_retire_state;
    decoded_instruction_type r_instr;
    logic                    r_mem_entry;
    logic                    w_wait_done;
    logic                    w_overflow;
    logic                    w_taken;
    logic [1:0]              w_op;

    mem_wait_timer #(
        .MEM_LATENCY (MEM_LATENCY),
        .MEM_MODE    (MEM_MODE)
    ) u_wait (
        .clk         (clk),
        .rst         (rst),
        .i_active    (is_mem_state(r_state)),
        .i_restart   (r_mem_entry),
        .i_mem_ready (mem_ready),
        .o_wait_done (w_wait_done)
    );

    assign w_retire_state = step_mode ? S_STEP_HOLD : S_FETCH;
    assign w_overflow     = OV_SIGNED ? signed_overflow : unsigned_overflow;
    assign operation      = OP_W'(w_op);

    // Branch condition, evaluated against the instruction latched at decode.
    always_comb begin
        case (r_instr)
            I_BRANCH: w_taken = 1'b1;
            I_BZERO:  w_taken = zero_op;
            I_BNZERO: w_taken = !zero_op;
            I_BNEG:   w_taken = neg_op;
            I_BNNEG:  w_taken = !neg_op;
            I_BOV:    w_taken = w_overflow;
            I_BNOV:   w_taken = !w_overflow;
            default:  w_taken = 1'b0;
        endcase
    end

    // State register, decoded-instruction latch and mem-window entry flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_instr     <= I_NOP;
            r_mem_entry <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_instr     <= (r_state == S_DECODE) ? decoded_instruction : r_instr;
            r_mem_entry <= is_mem_state(w_next_state) && (w_next_state != r_state);
        end
    end

    // Next-state and strobe decode; reset holds every output low.
    always_comb begin
        w_next_state     = r_state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        write_reg_enable = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        mem_req          = 1'b0;
        halt             = 1'b0;
        retired          = 1'b0;
        w_op             = OP_ADD;
        if (rst) begin
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    w_next_state = w_wait_done ? S_LATCH_IR : S_FETCH;
                end
                S_LATCH_IR: begin
                    ir_enable    = 1'b1;
                    pc_enable    = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    case (decoded_instruction)
                        I_ADD, I_SUB, I_AND, I_OR, I_MOVE: w_next_state = S_EXEC;
                        I_LOAD:  w_next_state = S_MEM_ADDR;
                        I_STORE: w_next_state = S_STORE_WR;
                        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                        I_BNNEG, I_BOV, I_BNOV: w_next_state = S_BR_EVAL;
                        I_HALT:  w_next_state = S_HALTED;
                        default: begin
                            retired      = 1'b1;
                            w_next_state = w_retire_state;
                        end
                    endcase
                end
                S_EXEC: begin
                    write_reg_enable = 1'b1;
                    flags_reg_enable = (r_instr != I_MOVE);
                    case (r_instr)
                        I_SUB:        w_op = OP_SUB;
                        I_AND:        w_op = OP_AND;
                        I_OR, I_MOVE: w_op = OP_OR;
                        default:      w_op = OP_ADD;
                    endcase
                    retired      = 1'b1;
                    w_next_state = w_retire_state;
                end
                S_MEM_ADDR: begin
                    addr_sel     = 1'b1;
                    c_sel        = 1'b1;
                    mem_req      = 1'b1;
                    w_next_state = w_wait_done ? S_LOAD_WB : S_MEM_ADDR;
                end
                S_LOAD_WB: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    retired          = 1'b1;
                    w_next_state     = w_retire_state;
                end
                S_STORE_WR: begin
                    addr_sel         = 1'b1;
                    mem_req          = 1'b1;
                    ram_write_enable = 1'b1;
                    retired          = w_wait_done;
                    w_next_state     = w_wait_done ? w_retire_state : S_STORE_WR;
                end
                S_BR_EVAL: begin
                    branch       = w_taken;
                    pc_enable    = w_taken;
                    retired      = 1'b1;
                    w_next_state = w_retire_state;
                end
                S_STEP_HOLD: begin
                    w_next_state = step ? S_FETCH : S_STEP_HOLD;
                end
                S_HALTED: begin
                    halt         = 1'b1;
                    w_next_state = S_HALTED;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_sequencer.sv
// Directed bench for ks_sequencer: a fixed-latency (L=3, signed overflow)
// instance and a handshake instance share stimulus; expectations are hand-built.
module tb_ks_sequencer;
    import k_and_s_pkg::*;

    localparam logic [12:0] B_NONE = 13'h0000;
    localparam logic [12:0] B_BR   = 13'h1000;
    localparam logic [12:0] B_PC   = 13'h0800;
    localparam logic [12:0] B_IR   = 13'h0400;
    localparam logic [12:0] B_WR   = 13'h0200;
    localparam logic [12:0] B_AS   = 13'h0100;
    localparam logic [12:0] B_CS   = 13'h0080;
    localparam logic [12:0] B_FL   = 13'h0040;
    localparam logic [12:0] B_WE   = 13'h0020;
    localparam logic [12:0] B_MEM  = 13'h0010;
    localparam logic [12:0] B_HALT = 13'h0008;
    localparam logic [12:0] B_RET  = 13'h0004;

    logic clk = 1'b0;
    logic rst, zero_op, neg_op, uov, sov, mem_ready, step_mode, step;
    decoded_instruction_type instr;

    logic fx_br, fx_pc, fx_ir, fx_wr, fx_as, fx_cs, fx_fl, fx_we, fx_mem, fx_halt, fx_ret;
    logic hs_br, hs_pc, hs_ir, hs_wr, hs_as, hs_cs, hs_fl, hs_we, hs_mem, hs_halt, hs_ret;
    logic [1:0] fx_op, hs_op;
    logic [12:0] w_fx, w_hs;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ks_sequencer #(.MEM_LATENCY(3), .MEM_MODE(MEM_FIXED), .OV_SIGNED(1'b1), .OP_W(2)) u_fix (
        .clk(clk), .rst(rst), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
        .mem_ready(mem_ready), .step_mode(step_mode), .step(step),
        .branch(fx_br), .pc_enable(fx_pc), .ir_enable(fx_ir), .write_reg_enable(fx_wr),
        .addr_sel(fx_as), .c_sel(fx_cs), .flags_reg_enable(fx_fl), .ram_write_enable(fx_we),
        .operation(fx_op), .mem_req(fx_mem), .halt(fx_halt), .retired(fx_ret)
    );

    ks_sequencer #(.MEM_LATENCY(3), .MEM_MODE(MEM_HANDSHAKE), .OV_SIGNED(1'b0), .OP_W(2)) u_hs (
        .clk(clk), .rst(rst), .decoded_instruction(instr),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
        .mem_ready(mem_ready), .step_mode(step_mode), .step(step),
        .branch(hs_br), .pc_enable(hs_pc), .ir_enable(hs_ir), .write_reg_enable(hs_wr),
        .addr_sel(hs_as), .c_sel(hs_cs), .flags_reg_enable(hs_fl), .ram_write_enable(hs_we),
        .operation(hs_op), .mem_req(hs_mem), .halt(hs_halt), .retired(hs_ret)
    );

    assign w_fx = {fx_br, fx_pc, fx_ir, fx_wr, fx_as, fx_cs, fx_fl, fx_we, fx_mem, fx_halt, fx_ret, fx_op};
    assign w_hs = {hs_br, hs_pc, hs_ir, hs_wr, hs_as, hs_cs, hs_fl, hs_we, hs_mem, hs_halt, hs_ret, hs_op};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves both instances in the first FETCH cycle with rst low.
    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_ready = 1'b1; step = 1'b1; step_mode = 1'b1; instr = I_HALT;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (w_fx !== B_NONE) begin n_bad++; $display("FAIL reset_fix: got %h expected %h", w_fx, B_NONE); end
        n_vec++;
        if (w_hs !== B_NONE) begin n_bad++; $display("FAIL reset_hs: got %h expected %h", w_hs, B_NONE); end
        tick();
        rst = 1'b0; mem_ready = 1'b0; step = 1'b0; step_mode = 1'b0;
        @(negedge clk);
        n_vec++;
        if (w_fx !== B_MEM) begin n_bad++; $display("FAIL first_fetch_fix: got %h expected %h", w_fx, B_MEM); end
        n_vec++;
        if (w_hs !== B_MEM) begin n_bad++; $display("FAIL first_fetch_hs: got %h expected %h", w_hs, B_MEM); end
        tick();
    endtask

    // Back-to-back ALU ops; the decoder input only carries the op in DECODE.
    task automatic test_alu;
        decoded_instruction_type ins [4] = '{I_ADD, I_SUB, I_AND, I_OR};
        logic [1:0] ops [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [12:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 6; c++) begin
                instr = (c == 5) ? ins[k] : I_HALT;
                case (c)
                    1, 2, 3: exp = B_MEM;
                    4:       exp = B_IR | B_PC;
                    5:       exp = B_NONE;
                    default: exp = B_WR | B_FL | B_RET | {11'd0, ops[k]};
                endcase
                @(negedge clk);
                n_vec++;
                if (w_fx !== exp) begin
                    n_bad++;
                    $display("FAIL alu[%0d] cycle %0d: got %h expected %h", k, c, w_fx, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_move_step;
        logic [12:0] exp;
        do_reset();
        step_mode = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            instr = (c == 5) ? I_MOVE : I_ADD;
            step  = (c == 2 || c == 14) ? 1'b1 : 1'b0;
            case (c)
                1, 2, 3, 15, 16: exp = B_MEM;
                4:               exp = B_IR | B_PC;
                6:               exp = B_WR | B_RET | 13'd3;
                default:         exp = B_NONE;
            endcase
            @(negedge clk);
            n_vec++;
            if (w_fx !== exp) begin
                n_bad++;
                $display("FAIL move_step cycle %0d: got %h expected %h", c, w_fx, exp);
            end
            tick();
        end
        step_mode = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_load;
        logic [12:0] exp;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            instr = (c == 5) ? I_LOAD : I_HALT;
            case (c)
                1, 2, 3, 10: exp = B_MEM;
                4:           exp = B_IR | B_PC;
                5:           exp = B_NONE;
                6, 7, 8:     exp = B_AS | B_CS | B_MEM;
                default:     exp = B_AS | B_CS | B_WR | B_RET;
            endcase
            @(negedge clk);
            n_vec++;
            if (w_fx !== exp) begin
                n_bad++;
                $display("FAIL load cycle %0d: got %h expected %h", c, w_fx, exp);
            end
            tick();
        end
    endtask

    // A full STORE, then a second STORE cut by reset in its second write cycle.
    task automatic test_store_reset;
        logic [12:0] exp;
        do_reset();
        for (int c = 1; c <= 19; c++) begin
            instr = (c == 5 || c == 13) ? I_STORE : I_ADD;
            rst   = (c == 15) ? 1'b1 : 1'b0;
            case (c)
                1, 2, 3, 9, 10, 11, 16, 17, 18: exp = B_MEM;
                4, 12, 19:                      exp = B_IR | B_PC;
                6, 7, 14:                       exp = B_AS | B_MEM | B_WE;
                8:                              exp = B_AS | B_MEM | B_WE | B_RET;
                default:                        exp = B_NONE;
            endcase
            @(negedge clk);
            n_vec++;
            if (w_fx !== exp) begin
                n_bad++;
                $display("FAIL store_reset cycle %0d: got %h expected %h", c, w_fx, exp);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    // Flags are applied only during BR_EVAL and inverted elsewhere.
    task automatic test_branch;
        decoded_instruction_type ins [6] = '{I_BNOV, I_BZERO, I_BOV, I_BOV, I_BNNEG, I_BRANCH};
        logic zv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic nv [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic uv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic sv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic tk [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [12:0] exp;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int c = 1; c <= 6; c++) begin
                instr   = (c == 5) ? ins[k] : I_NOP;
                zero_op = (c == 6) ? zv[k] : !zv[k];
                neg_op  = (c == 6) ? nv[k] : !nv[k];
                uov     = (c == 6) ? uv[k] : !uv[k];
                sov     = (c == 6) ? sv[k] : !sv[k];
                case (c)
                    1, 2, 3: exp = B_MEM;
                    4:       exp = B_IR | B_PC;
                    5:       exp = B_NONE;
                    default: exp = tk[k] ? (B_BR | B_PC | B_RET) : B_RET;
                endcase
                @(negedge clk);
                n_vec++;
                if (w_fx !== exp) begin
                    n_bad++;
                    $display("FAIL branch[%0d] cycle %0d: got %h expected %h", k, c, w_fx, exp);
                end
                tick();
            end
        end
    endtask

    task automatic test_halt;
        logic [12:0] exp;
        logic [12:0] obs;
        do_reset();
        for (int c = 1; c <= 27; c++) begin
            instr     = (c == 5) ? I_HALT : ((c > 5 && c[0]) ? I_LOAD : I_ADD);
            step      = (c > 5) ? c[0] : 1'b0;
            mem_ready = (c > 5) ? !c[0] : 1'b0;
            step_mode = (c > 5 && c < 26) ? c[1] : 1'b0;
            rst       = (c == 26) ? 1'b1 : 1'b0;
            case (c)
                1, 2, 3, 27: exp = B_MEM;
                4:           exp = B_IR | B_PC;
                5, 26:       exp = B_NONE;
                default:     exp = B_HALT;
            endcase
            @(negedge clk);
            obs = (c == 5) ? (w_fx & ~B_RET) : w_fx;
            n_vec++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL halt cycle %0d: got %h expected %h", c, obs, exp);
            end
            tick();
        end
        rst = 1'b0; step = 1'b0; mem_ready = 1'b0; step_mode = 1'b0;
    endtask

    // LOAD on the handshake instance: ready on fetch cycle 5 and data cycle 2.
    task automatic test_handshake;
        logic [12:0] exp;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            instr     = (c == 7) ? I_LOAD : I_HALT;
            mem_ready = (c >= 5 && c <= 7) || (c == 9) || (c == 10);
            case (c)
                1, 2, 3, 4, 5, 11: exp = B_MEM;
                6:                 exp = B_IR | B_PC;
                7:                 exp = B_NONE;
                8, 9:              exp = B_AS | B_CS | B_MEM;
                default:           exp = B_AS | B_CS | B_WR | B_RET;
            endcase
            @(negedge clk);
            n_vec++;
            if (w_hs !== exp) begin
                n_bad++;
                $display("FAIL handshake cycle %0d: got %h expected %h", c, w_hs, exp);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; zero_op = 1'b0; neg_op = 1'b0; uov = 1'b0; sov = 1'b0;
        mem_ready = 1'b0; step_mode = 1'b0; step = 1'b0; instr = I_NOP;
        #1;
        test_reset();
        test_alu();
        test_move_step();
        test_load();
        test_store_reset();
        test_branch();
        test_halt();
        test_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
